// File: rtl/multi_updown_counter_if.sv
// Bundle of the counter bank's per-channel data/strobe signals.
// Optional threshold signals appear when COUNTER_THRESH_EN is defined.
interface multi_updown_counter_if #(
  parameter int WIDTH    = 8,
  parameter int INC_SIZE = 1,
  parameter int DEC_SIZE = 1,
  parameter int NUM_CH   = 2
);
  logic [NUM_CH*INC_SIZE-1:0] inc;
  logic [NUM_CH*DEC_SIZE-1:0] dec;
  logic [NUM_CH-1:0]          load;
  logic [NUM_CH*WIDTH-1:0]    load_val;
  logic                       clr_flags;
  logic [NUM_CH*WIDTH-1:0]    count;
  logic [NUM_CH-1:0]          at_max;
  logic [NUM_CH-1:0]          at_min;
  logic [NUM_CH-1:0]          ovf;
  logic [NUM_CH-1:0]          unf;
`ifdef COUNTER_THRESH_EN
  logic [NUM_CH*WIDTH-1:0]    thresh;
  logic [NUM_CH-1:0]          above_thresh;

  modport master (
    output inc, dec, load, load_val, clr_flags, thresh,
    input  count, at_max, at_min, ovf, unf, above_thresh
  );
  modport slave (
    input  inc, dec, load, load_val, clr_flags, thresh,
    output count, at_max, at_min, ovf, unf, above_thresh
  );
`else
  modport master (
    output inc, dec, load, load_val, clr_flags,
    input  count, at_max, at_min, ovf, unf
  );
  modport slave (
    input  inc, dec, load, load_val, clr_flags,
    output count, at_max, at_min, ovf, unf
  );
`endif
endinterface

// File: rtl/multi_updown_counter.sv
// Bank of NUM_CH independent up/down counters with load, saturate/wrap and sticky flags.
// Define COUNTER_THRESH_EN to add per-channel registered threshold compare.
module multi_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int INC_SIZE = 1,
  parameter int DEC_SIZE = 1,
  parameter int NUM_CH   = 2,
  parameter int WRAP     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_updown_counter_if.slave bus
);

  localparam int STEP_W = (INC_SIZE > DEC_SIZE) ? INC_SIZE : DEC_SIZE;
  localparam int EXT_W  = WIDTH + STEP_W + 2;
  localparam logic signed [EXT_W-1:0] MAX_S = {{(STEP_W+2){1'b0}}, {WIDTH{1'b1}}};

  logic signed [EXT_W-1:0] sum_p0  [NUM_CH];
  logic [WIDTH-1:0]        nxt_cnt [NUM_CH];
  logic [WIDTH-1:0]        cnt_p1  [NUM_CH];
  logic [NUM_CH-1:0]       ovf_set;
  logic [NUM_CH-1:0]       unf_set;
  logic [NUM_CH-1:0]       ovf_p1;
  logic [NUM_CH-1:0]       unf_p1;
  logic [NUM_CH*WIDTH-1:0] count_pk;
  logic [NUM_CH-1:0]       at_max_c;
  logic [NUM_CH-1:0]       at_min_c;

  function automatic logic is_ovf(input logic signed [EXT_W-1:0] r);
    return r > MAX_S;
  endfunction

  function automatic logic is_unf(input logic signed [EXT_W-1:0] r);
    return r[EXT_W-1];
  endfunction

  // Saturate to [0, 2**WIDTH-1] or take the low bits for modulo wrap.
  function automatic logic [WIDTH-1:0] limit(input logic signed [EXT_W-1:0] r);
    logic [WIDTH-1:0] res;
    res = r[WIDTH-1:0];
    if (WRAP == 0) begin
      if (is_ovf(r))      res = {WIDTH{1'b1}};
      else if (is_unf(r)) res = '0;
    end
    return res;
  endfunction

  // Stage p0: full-precision net sum and next-state selection
  always_comb begin
    ovf_set = '0;
    unf_set = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sum_p0[ch] = $signed({{(EXT_W-WIDTH){1'b0}}, cnt_p1[ch]})
                 + $signed({{(EXT_W-INC_SIZE){1'b0}}, bus.inc[ch*INC_SIZE +: INC_SIZE]})
                 - $signed({{(EXT_W-DEC_SIZE){1'b0}}, bus.dec[ch*DEC_SIZE +: DEC_SIZE]});
      if (bus.load[ch]) begin
        nxt_cnt[ch] = bus.load_val[ch*WIDTH +: WIDTH];
      end else begin
        nxt_cnt[ch] = limit(sum_p0[ch]);
        ovf_set[ch] = is_ovf(sum_p0[ch]);
        unf_set[ch] = is_unf(sum_p0[ch]);
      end
    end
  end

  // Stage p1: count and sticky flag registers (set beats clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) cnt_p1[ch] <= '0;
      ovf_p1 <= '0;
      unf_p1 <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) cnt_p1[ch] <= nxt_cnt[ch];
      ovf_p1 <= (ovf_p1 & ~{NUM_CH{bus.clr_flags}}) | ovf_set;
      unf_p1 <= (unf_p1 & ~{NUM_CH{bus.clr_flags}}) | unf_set;
    end
  end

  always_comb begin
    count_pk = '0;
    at_max_c = '0;
    at_min_c = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      count_pk[ch*WIDTH +: WIDTH] = cnt_p1[ch];
      at_max_c[ch] = &cnt_p1[ch];
      at_min_c[ch] = ~|cnt_p1[ch];
    end
  end

  assign bus.count  = count_pk;
  assign bus.at_max = at_max_c;
  assign bus.at_min = at_min_c;
  assign bus.ovf    = ovf_p1;
  assign bus.unf    = unf_p1;

`ifdef COUNTER_THRESH_EN
  logic [NUM_CH-1:0] above_p1;

  // Compare against the next count so the flag lines up with count itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      above_p1 <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++)
        above_p1[ch] <= (nxt_cnt[ch] >= bus.thresh[ch*WIDTH +: WIDTH]);
    end
  end

  assign bus.above_thresh = above_p1;
`endif

endmodule

// File: tb/tb_multi_updown_counter.sv
// Directed bench for multi_updown_counter: saturating and wrapping instances side by side.
module tb_multi_updown_counter;
  localparam int W = 8, IS = 2, DS = 2, NC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multi_updown_counter_if #(.WIDTH(W), .INC_SIZE(IS), .DEC_SIZE(DS), .NUM_CH(NC)) bs ();
  multi_updown_counter_if #(.WIDTH(W), .INC_SIZE(IS), .DEC_SIZE(DS), .NUM_CH(NC)) bw ();

  multi_updown_counter #(.WIDTH(W), .INC_SIZE(IS), .DEC_SIZE(DS), .NUM_CH(NC), .WRAP(0))
    dut_sat (.clk(clk), .rst_n(rst_n), .bus(bs));
  multi_updown_counter #(.WIDTH(W), .INC_SIZE(IS), .DEC_SIZE(DS), .NUM_CH(NC), .WRAP(1))
    dut_wrap (.clk(clk), .rst_n(rst_n), .bus(bw));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_sat();
    bs.inc = '0; bs.dec = '0; bs.load = '0; bs.load_val = '0; bs.clr_flags = 1'b0;
  endtask

  task automatic idle_wrap();
    bw.inc = '0; bw.dec = '0; bw.load = '0; bw.load_val = '0; bw.clr_flags = 1'b0;
  endtask

  initial begin
    // Reset held with random activity on the inputs
    bs.inc = 4'($urandom); bs.dec = 4'($urandom); bs.load = 2'($urandom);
    bs.load_val = 16'($urandom); bs.clr_flags = 1'($urandom);
    idle_wrap();
`ifdef COUNTER_THRESH_EN
    bs.thresh = {8'd255, 8'd10};
    bw.thresh = '0;
`endif
    step(); step();
    chk("rst_count", 32'(bs.count), 32'd0);
    chk("rst_at_min", 32'(bs.at_min), 32'd3);
    chk("rst_at_max", 32'(bs.at_max), 32'd0);
    chk("rst_ovf", 32'(bs.ovf), 32'd0);
    chk("rst_unf", 32'(bs.unf), 32'd0);
`ifdef COUNTER_THRESH_EN
    chk("rst_above", 32'(bs.above_thresh), 32'd0);
`endif
    idle_sat();
    step();
    rst_n = 1'b1;

    // Saturate up: ch0 +3 per cycle
    bs.inc = 4'b0011;
    for (int k = 1; k <= 90; k++) begin
      step();
      chk($sformatf("satup_cnt0_k%0d", k), 32'(bs.count[7:0]), (3 * k > 255) ? 32'd255 : 32'(3 * k));
      chk($sformatf("satup_ovf0_k%0d", k), 32'(bs.ovf[0]), (3 * k > 255) ? 32'd1 : 32'd0);
    end
    chk("satup_at_max", 32'(bs.at_max), 32'd1);
    chk("satup_cnt1", 32'(bs.count[15:8]), 32'd0);

    // Load ch0 = 4 while clearing flags
    idle_sat();
    bs.load = 2'b01; bs.load_val = {8'd0, 8'd4}; bs.clr_flags = 1'b1;
    step();
    chk("ld4_cnt0", 32'(bs.count[7:0]), 32'd4);
    chk("ld4_ovf", 32'(bs.ovf), 32'd0);

    // inc=1 dec=3 on ch0: 4 -> 2 -> 0 -> 0 with unf
    idle_sat();
    bs.inc = 4'b0001; bs.dec = 4'b0011;
    step();
    chk("dn_cnt0_a", 32'(bs.count[7:0]), 32'd2);
    step();
    chk("dn_cnt0_b", 32'(bs.count[7:0]), 32'd0);
    chk("dn_unf_exact0", 32'(bs.unf), 32'd0);
    step();
    chk("dn_cnt0_c", 32'(bs.count[7:0]), 32'd0);
    chk("dn_unf_set", 32'(bs.unf), 32'd1);
    bs.clr_flags = 1'b1;
    step();
    chk("dn_unf_setwins", 32'(bs.unf), 32'd1);
    bs.inc = '0; bs.dec = '0;
    step();
    chk("dn_unf_clr", 32'(bs.unf), 32'd0);
    chk("dn_at_min", 32'(bs.at_min), 32'd3);

    // Load priority on ch1
    idle_sat();
    bs.load = 2'b10; bs.load_val = {8'd200, 8'd77}; bs.inc = 4'b1100;
    step();
    chk("ldp_cnt1", 32'(bs.count[15:8]), 32'd200);
    chk("ldp_cnt0", 32'(bs.count[7:0]), 32'd0);
    chk("ldp_ovf", 32'(bs.ovf), 32'd0);
    bs.load = '0;
    step();
    chk("ldp_cnt1_inc", 32'(bs.count[15:8]), 32'd203);
    bs.inc = 4'b1100; bs.dec = 4'b1100;
    step();
    chk("net_cnt1", 32'(bs.count[15:8]), 32'd203);

    // Wrap instance
    bw.load = 2'b01; bw.load_val = {8'd0, 8'd254};
    idle_sat();
    step();
    chk("wr_ld", 32'(bw.count[7:0]), 32'd254);
    bw.load = '0; bw.inc = 4'b0011;
    step();
    chk("wr_up_cnt", 32'(bw.count[7:0]), 32'd1);
    chk("wr_up_ovf", 32'(bw.ovf), 32'd1);
    bw.inc = '0; bw.dec = 4'b0010;
    step();
    chk("wr_dn_cnt", 32'(bw.count[7:0]), 32'd255);
    chk("wr_dn_unf", 32'(bw.unf), 32'd1);
    chk("wr_at_max", 32'(bw.at_max), 32'd1);
    idle_wrap();

`ifdef COUNTER_THRESH_EN
    // Threshold 10 on ch0, counting +1 from 0
    bs.load = 2'b01; bs.load_val = '0;
    step();
    bs.load = '0; bs.inc = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("th_cnt0_k%0d", k), 32'(bs.count[7:0]), 32'(k));
      chk($sformatf("th_above0_k%0d", k), 32'(bs.above_thresh[0]), (k >= 10) ? 32'd1 : 32'd0);
    end
    bs.inc = '0; bs.load = 2'b01; bs.load_val = {8'd0, 8'd5};
    step();
    chk("th_ld_cnt0", 32'(bs.count[7:0]), 32'd5);
    chk("th_ld_above0", 32'(bs.above_thresh[0]), 32'd0);
    idle_sat();
`endif

    // Asynchronous reset mid-count
    bs.inc = 4'b0100;
    step();
    step();
    chk("pre_rst_nonzero", 32'(bs.count != '0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bs.count), 32'd0);
    chk("arst_wcount", 32'(bw.count), 32'd0);
    chk("arst_wovf", 32'(bw.ovf), 32'd0);
    chk("arst_wunf", 32'(bw.unf), 32'd0);
    chk("arst_at_min", 32'(bs.at_min), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multi_updown_counter.md
Name: multi_updown_counter

Overview:
- Parametrised successor to the single up/down counter: NUM_CH independent up/down counters in one block.
- Each channel takes a multi-bit increment step and a multi-bit decrement step per cycle, supports synchronous load, and runs in saturate or wrap mode.
- Provides min/max status and sticky overflow/underflow flags.
- Used as the event/credit counting bank in the datapath; replaces per-instance scalar counters.

Parameters:
- WIDTH, 8: count width per channel (bits).
- INC_SIZE, 1: width of per-channel increment step (unsigned amount added per cycle).
- DEC_SIZE, 1: width of per-channel decrement step (unsigned amount subtracted per cycle).
- NUM_CH, 2: number of independent channels (>=1).
- WRAP, 0: 0 = saturate at 0 and 2**WIDTH-1; 1 = modulo 2**WIDTH wrap.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- inc  input  NUM_CH*INC_SIZE  per-channel increment amount; channel i at [i*INC_SIZE +: INC_SIZE]
- dec  input  NUM_CH*DEC_SIZE  per-channel decrement amount; channel i at [i*DEC_SIZE +: DEC_SIZE]
- load  input  NUM_CH  per-channel synchronous load strobe
- load_val  input  NUM_CH*WIDTH  per-channel load value
- clr_flags  input  1  clears all sticky flags (all channels)
- count  output  NUM_CH*WIDTH  registered per-channel count
- at_max  output  NUM_CH  count[i] == 2**WIDTH-1 (combinational from register)
- at_min  output  NUM_CH  count[i] == 0 (combinational from register)
- ovf  output  NUM_CH  sticky: true result exceeded 2**WIDTH-1
- unf  output  NUM_CH  sticky: true result went below 0

Behaviour:
- Reset (rst_n low, asynchronous): count = 0, ovf = 0, unf = 0 for all channels; hence at_min = all 1s and at_max = all 0s. Release is synchronous to clk by the upstream reset synchroniser.
- Latency: inputs sampled on rising edge; count updates on that edge, visible one cycle after the inputs are presented.
- Per-channel priority: load > inc/dec. With load[i] = 1, count[i] <= load_val[i]; inc/dec for that channel are ignored that cycle, and ovf/unf do not set from that channel.
- Arithmetic without load: compute r = count + inc - dec as a signed value of WIDTH + max(INC_SIZE, DEC_SIZE) + 2 bits, with no intermediate truncation.
  - inc and dec both nonzero in the same cycle: net applied (e.g. 5 + 3 - 3 = 5).
  - inc = dec = 0: hold.
- Saturate mode (WRAP = 0):
  - r > 2**WIDTH-1: count = 2**WIDTH-1 and ovf set.
  - r < 0: count = 0 and unf set.
  - Otherwise count = r.
- Wrap mode (WRAP = 1): count = r mod 2**WIDTH. ovf/unf set under the same out-of-range conditions (wrap event indication).
- Sticky flags:
  - Remain set until clr_flags = 1 at a rising edge.
  - If a set condition and clr_flags occur in the same cycle, the flag ends set (set wins).
- Channel independence: no cross-channel interaction; a load on one channel does not affect the others.
- Steady saturation: at max with inc > 0 and dec = 0, count holds at max and ovf stays/becomes set every such cycle. The min case is symmetric.
- Reset mid-operation: all state clears immediately regardless of clk.

Optional Feature:
- Macro COUNTER_THRESH_EN.
- When defined:
  - Adds input thresh (NUM_CH*WIDTH) and output above_thresh (NUM_CH).
  - above_thresh[i] is registered: on each edge it is set to (next count[i] >= thresh[i]), so it is aligned with count with no extra cycle.
  - Reset value 0.
- When undefined: these ports and their logic are absent; all other behaviour is unchanged.

Test Plan (WIDTH=8, INC_SIZE=2, DEC_SIZE=2, NUM_CH=2 unless noted):
- Reset: hold rst_n = 0, drive random inputs -> count = 0, at_min = 2'b11, ovf = unf = 0. Assert rst_n = 0 mid-count -> immediate clear without a clock edge.
- Saturate up: ch0 inc = 3 for 90 cycles -> count0 = 255 from cycle 85 on, at_max[0] = 1, ovf[0] = 1. ch1 untouched stays 0.
- Saturate down with simultaneous events: ch0 at 4, inc = 1 and dec = 3 -> 2, then 0; one more cycle -> stays 0 with unf[0] = 1. clr_flags together with an underflow cycle -> unf stays 1. clr_flags alone -> unf = 0.
- Load priority: ch1 load = 1, load_val = 200, inc = 3 same cycle -> count1 = 200 next cycle, ovf[1] unchanged. Next cycle inc = 3 -> 203.
- Wrap mode (WRAP = 1): ch0 at 254, inc = 3 -> 1 and ovf[0] = 1. At 1, dec = 2 -> 255 and unf[0] = 1.
- With COUNTER_THRESH_EN: thresh0 = 10, ch0 counting +1 from 0 -> above_thresh[0] rises in the same cycle count0 becomes 10. Load 5 -> above_thresh[0] falls together with count0 = 5.
